// File: rtl/wb_initiator.sv
// Wishbone classic initiator: single or incrementing-burst reads/writes driven by a
// command port, with write/read beat streams and a per-beat ack timeout abort.
module wb_initiator #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [3:0]  cmd_sel,
    input  logic [7:0]  cmd_len,
    input  logic [31:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WDATA = 2'd1;
    localparam logic [1:0] S_BUS   = 2'd2;
    localparam logic [1:0] S_RDATA = 2'd3;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic        r_cmd_ready;
    logic        r_wr_ready;
    logic [31:0] r_rd_data;
    logic        r_rd_valid;
    logic        r_cyc;
    logic        r_stb;
    logic        r_we;
    logic [3:0]  r_sel;
    logic [31:0] r_adr;
    logic [31:0] r_dat_o;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic [7:0]  r_cnt;
    logic        r_more;
    logic [15:0] r_tcnt;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_wr_ready  <= 1'b0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= '0;
            r_adr       <= '0;
            r_dat_o     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            r_more      <= 1'b0;
            r_tcnt      <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_cyc       <= 1'b1;
                        r_we        <= cmd_we;
                        r_adr       <= cmd_adr;
                        r_sel       <= cmd_sel;
                        r_cnt       <= cmd_len;
                        r_tcnt      <= '0;
                        if (cmd_we) begin
                            r_wr_ready <= 1'b1;
                            r_state    <= S_WDATA;
                        end else begin
                            r_stb   <= 1'b1;
                            r_state <= S_BUS;
                        end
                    end
                end
                S_WDATA: begin
                    if (wr_valid) begin
                        r_dat_o    <= wr_data;
                        r_wr_ready <= 1'b0;
                        r_stb      <= 1'b1;
                        r_tcnt     <= '0;
                        r_state    <= S_BUS;
                    end
                end
                S_BUS: begin
                    // An ack on the timeout cycle takes priority over the abort.
                    if (wbm_ack_i) begin
                        r_stb  <= 1'b0;
                        r_adr  <= r_adr + 32'd4;
                        r_cnt  <= r_cnt - 8'd1;
                        r_more <= (r_cnt != '0);
                        if (!r_we) begin
                            r_rd_data  <= wbm_dat_i;
                            r_rd_valid <= 1'b1;
                            r_state    <= S_RDATA;
                        end else if (r_cnt != '0) begin
                            r_wr_ready <= 1'b1;
                            r_state    <= S_WDATA;
                        end else begin
                            r_cyc       <= 1'b0;
                            r_we        <= 1'b0;
                            r_done      <= 1'b1;
                            r_busy      <= 1'b0;
                            r_cmd_ready <= 1'b1;
                            r_state     <= S_IDLE;
                        end
                    end else if (r_tcnt == TO_LAST) begin
                        r_stb       <= 1'b0;
                        r_cyc       <= 1'b0;
                        r_we        <= 1'b0;
                        r_err       <= 1'b1;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + 16'd1;
                    end
                end
                S_RDATA: begin
                    if (rd_ready) begin
                        r_rd_valid <= 1'b0;
                        if (r_more) begin
                            r_stb   <= 1'b1;
                            r_tcnt  <= '0;
                            r_state <= S_BUS;
                        end else begin
                            r_cyc       <= 1'b0;
                            r_we        <= 1'b0;
                            r_done      <= 1'b1;
                            r_busy      <= 1'b0;
                            r_cmd_ready <= 1'b1;
                            r_state     <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign wr_ready  = r_wr_ready;
    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_stb;
    assign wbm_we_o  = r_we;
    assign wbm_sel_o = r_sel;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat_o;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_wb_initiator.sv
// Bench for wb_initiator: two instances (TIMEOUT 255 and 8), a behavioural
// responder per instance, and queue-based scoreboards for bus beats and read data.
module tb_wb_initiator;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid [2];
    logic        cmd_ready [2];
    logic        cmd_we    [2];
    logic [31:0] cmd_adr   [2];
    logic [3:0]  cmd_sel   [2];
    logic [7:0]  cmd_len   [2];
    logic [31:0] wr_data   [2];
    logic        wr_valid  [2];
    logic        wr_ready  [2];
    logic [31:0] rd_data   [2];
    logic        rd_valid  [2];
    logic        rd_ready  [2];
    logic        cyc       [2];
    logic        stb       [2];
    logic        we        [2];
    logic [3:0]  sel       [2];
    logic [31:0] adr       [2];
    logic [31:0] dat_o     [2];
    logic [31:0] dat_i     [2];
    logic        ack       [2];
    logic        busy      [2];
    logic        done      [2];
    logic        err       [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        wb_initiator #(.TIMEOUT(g == 0 ? 255 : 8)) u_dut (
            .wb_clk_i  (clk),
            .wb_rst_n_i(rst_n),
            .cmd_valid (cmd_valid[g]),
            .cmd_ready (cmd_ready[g]),
            .cmd_we    (cmd_we[g]),
            .cmd_adr   (cmd_adr[g]),
            .cmd_sel   (cmd_sel[g]),
            .cmd_len   (cmd_len[g]),
            .wr_data   (wr_data[g]),
            .wr_valid  (wr_valid[g]),
            .wr_ready  (wr_ready[g]),
            .rd_data   (rd_data[g]),
            .rd_valid  (rd_valid[g]),
            .rd_ready  (rd_ready[g]),
            .wbm_cyc_o (cyc[g]),
            .wbm_stb_o (stb[g]),
            .wbm_we_o  (we[g]),
            .wbm_sel_o (sel[g]),
            .wbm_adr_o (adr[g]),
            .wbm_dat_o (dat_o[g]),
            .wbm_dat_i (dat_i[g]),
            .wbm_ack_i (ack[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .err       (err[g])
        );
    end

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
    } bus_t;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [7:0]  len;
        int          lat;
        logic [31:0] wbase;
        int          exp_stb;
    } vec_t;

    bus_t        bus_q [$];
    logic [31:0] rd_q  [$];
    logic [31:0] wr_q  [$];

    int          checks = 0;
    int          failures = 0;
    int          act = 0;
    int          lat   [2];
    bit          noack [2];
    int          scnt  [2];
    logic [31:0] mem       [2][16];
    logic [31:0] model_mem [2][16];

    int   rd_idx = 0, bp_at = -1, bp_left = 0;
    int   n_done = 0, n_err = 0, n_stb = 0, n_stall = 0;
    bit   p_acc, p_rhs, p_whs, p_ack, p_stb, p_wrr, p_rdv, whs;
    bus_t m_e;
    vec_t vecs [5];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Responder: acks on the (lat+1)-th consecutive stb cycle unless noack is set.
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            ack[d]   = stb[d] && !noack[d] && (scnt[d] == lat[d]);
            dat_i[d] = mem[d][adr[d][5:2]];
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++)
            scnt[d] <= (!rst_n || !stb[d] || ack[d]) ? 0 : scnt[d] + 1;
    end

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, a, e);
        end
    endtask

    task automatic chk1(input string name, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: actual=%0b required=%0b", name, a, e);
        end
    endtask

    task automatic check_reset(input int d);
        chk1("rst_cmd_ready", cmd_ready[d], 1'b1);
        chk1("rst_cyc", cyc[d], 1'b0);
        chk1("rst_stb", stb[d], 1'b0);
        chk1("rst_we", we[d], 1'b0);
        chk("rst_sel", 32'(sel[d]), 32'd0);
        chk("rst_adr", adr[d], 32'd0);
        chk("rst_dat_o", dat_o[d], 32'd0);
        chk1("rst_wr_ready", wr_ready[d], 1'b0);
        chk1("rst_rd_valid", rd_valid[d], 1'b0);
        chk("rst_rd_data", rd_data[d], 32'd0);
        chk1("rst_busy", busy[d], 1'b0);
        chk1("rst_done", done[d], 1'b0);
        chk1("rst_err", err[d], 1'b0);
    endtask

    task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [7:0] len, input int l, input logic [31:0] wbase);
        bus_t e;
        bit   acc;
        act    = d;
        lat[d] = l;
        for (int b = 0; b <= int'(len); b++) begin
            e.adr = a + 32'(4 * b);
            e.we  = w;
            e.sel = s;
            e.dat = w ? wbase + 32'(b) : 32'd0;
            bus_q.push_back(e);
            if (w) begin
                wr_q.push_back(e.dat);
                model_mem[d][e.adr[5:2]] = e.dat;
            end else begin
                rd_q.push_back(model_mem[d][e.adr[5:2]]);
            end
        end
        @(posedge clk);
        #1;
        cmd_we[d]    = w;
        cmd_adr[d]   = a;
        cmd_sel[d]   = s;
        cmd_len[d]   = len;
        cmd_valid[d] = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready[d]) begin
                acc = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
        end
        cmd_valid[d] = 1'b0;
        chk1("cmd_accept", acc, 1'b1);
    endtask

    task automatic wait_end(input int d, input int maxc, output bit gd, output bit ge);
        gd = 1'b0;
        ge = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (done[d]) gd = 1'b1;
            if (err[d])  ge = 1'b1;
            if (gd || ge) break;
        end
        if (!gd && !ge) chk1("end_wait_expired", 1'b0, 1'b1);
    endtask

    initial begin
        bit gd, ge, ok;
        int s0, e0, d0, st0, r0;

        vecs[0] = '{we: 1'b1, adr: 32'h3800_0010, sel: 4'hF, len: 8'd0, lat: 10, wbase: 32'hDEAD_BEEF, exp_stb: 11};
        vecs[1] = '{we: 1'b0, adr: 32'h3800_0000, sel: 4'hF, len: 8'd3, lat: 0,  wbase: 32'h0,         exp_stb: 4};
        vecs[2] = '{we: 1'b1, adr: 32'h3800_0020, sel: 4'hF, len: 8'd2, lat: 2,  wbase: 32'h0000_00A0, exp_stb: 9};
        vecs[3] = '{we: 1'b0, adr: 32'h3800_0020, sel: 4'h3, len: 8'd2, lat: 1,  wbase: 32'h0,         exp_stb: 6};
        vecs[4] = '{we: 1'b0, adr: 32'h3000_0010, sel: 4'h1, len: 8'd0, lat: 3,  wbase: 32'h0,         exp_stb: 4};

        for (int d = 0; d < 2; d++) begin
            cmd_valid[d] = 1'b0;
            cmd_we[d]    = 1'b0;
            cmd_adr[d]   = '0;
            cmd_sel[d]   = '0;
            cmd_len[d]   = '0;
            wr_data[d]   = '0;
            wr_valid[d]  = 1'b0;
            rd_ready[d]  = 1'b1;
            lat[d]       = 0;
            noack[d]     = 1'b0;
            for (int i = 0; i < 16; i++) begin
                mem[d][i]       = 32'(i + 1);
                model_mem[d][i] = 32'(i + 1);
            end
        end
        rst_n = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    {p_acc, p_rhs, p_whs, p_ack, p_stb, p_wrr, p_rdv} = '0;
                end else begin
                    if (stb[act] && ack[act]) begin
                        if (bus_q.size() == 0) begin
                            chk1("bus_unexpected_beat", 1'b1, 1'b0);
                        end else begin
                            m_e = bus_q.pop_front();
                            chk("bus_adr", adr[act], m_e.adr);
                            chk1("bus_we", we[act], m_e.we);
                            chk("bus_sel", 32'(sel[act]), 32'(m_e.sel));
                            if (m_e.we) chk("bus_wdat", dat_o[act], m_e.dat);
                        end
                        if (we[act]) mem[act][adr[act][5:2]] = dat_o[act];
                    end
                    if (rd_valid[act] && rd_ready[act]) begin
                        if (rd_q.size() == 0) chk1("rd_unexpected_beat", 1'b1, 1'b0);
                        else chk("rd_data", rd_data[act], rd_q.pop_front());
                        rd_idx++;
                    end else if (rd_valid[act] && rd_q.size() > 0) begin
                        n_stall++;
                        chk("bp_rd_data_held", rd_data[act], rd_q[0]);
                        chk1("bp_stb_low", stb[act], 1'b0);
                    end
                    if (stb[act] && !p_stb) chk1("stb_rise_cause", p_acc || p_rhs || p_whs, 1'b1);
                    if (wr_ready[act] && !p_wrr) chk1("wr_ready_rise_cause", p_acc || p_ack, 1'b1);
                    if (rd_valid[act] && !p_rdv) chk1("rd_valid_rise_cause", p_ack, 1'b1);
                    if (done[act] || err[act]) begin
                        chk1("end_busy_low", busy[act], 1'b0);
                        chk1("end_cmd_ready", cmd_ready[act], 1'b1);
                        chk1("end_cyc_low", cyc[act], 1'b0);
                        chk1("end_done_and_err", done[act] && err[act], 1'b0);
                    end
                    if (done[act]) n_done++;
                    if (err[act])  n_err++;
                    if (stb[act])  n_stb++;
                    p_acc = cmd_valid[act] && cmd_ready[act];
                    p_rhs = rd_valid[act] && rd_ready[act];
                    p_whs = wr_valid[act] && wr_ready[act];
                    p_ack = stb[act] && ack[act];
                    p_stb = stb[act];
                    p_wrr = wr_ready[act];
                    p_rdv = rd_valid[act];
                end
            end
            forever begin
                @(posedge clk);
                whs = wr_valid[act] && wr_ready[act];
                #1;
                if (whs && wr_q.size() > 0) void'(wr_q.pop_front());
                for (int d = 0; d < 2; d++) wr_valid[d] = 1'b0;
                wr_valid[act] = (wr_q.size() != 0);
                wr_data[act]  = (wr_q.size() != 0) ? wr_q[0] : 32'd0;
                if (rd_valid[act] && (rd_idx + 1 == bp_at) && bp_left > 0) begin
                    rd_ready[act] = 1'b0;
                    bp_left--;
                end else begin
                    rd_ready[act] = 1'b1;
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check_reset(0);
        check_reset(1);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            s0 = n_stb;
            d0 = n_done;
            issue(0, vecs[v].we, vecs[v].adr, vecs[v].sel, vecs[v].len, vecs[v].lat, vecs[v].wbase);
            wait_end(0, 200, gd, ge);
            chk1("vec_done", gd, 1'b1);
            chk1("vec_no_err", ge, 1'b0);
            chk("vec_stb_cycles", 32'(n_stb - s0), 32'(vecs[v].exp_stb));
            @(negedge clk);
            chk("vec_single_done", 32'(n_done - d0), 32'd1);
            chk("vec_queues_drained", 32'(bus_q.size() + rd_q.size() + wr_q.size()), 32'd0);
        end

        // Backpressure: hold rd_ready low for 5 cycles on beat 2.
        st0   = n_stall;
        bp_at = rd_idx + 2;
        bp_left = 5;
        issue(0, 1'b0, 32'h3800_0000, 4'hF, 8'd3, 0, 32'h0);
        wait_end(0, 200, gd, ge);
        chk1("bp_done", gd, 1'b1);
        chk("bp_stall_cycles", 32'(n_stall - st0), 32'd5);
        chk("bp_queues_drained", 32'(bus_q.size() + rd_q.size()), 32'd0);
        bp_at = -1;

        // Reset during beat 2's bus phase.
        r0 = rd_idx;
        issue(0, 1'b0, 32'h3800_0000, 4'hF, 8'd3, 4, 32'h0);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (stb[0] && rd_idx == r0 + 1) begin
                ok = 1'b1;
                break;
            end
        end
        chk1("rst_mid_reached_beat2", ok, 1'b1);
        rst_n = 1'b0;
        bus_q.delete();
        rd_q.delete();
        wr_q.delete();
        @(posedge clk);
        #1;
        check_reset(0);
        rst_n = 1'b1;
        issue(0, 1'b1, 32'h3800_0030, 4'hF, 8'd1, 0, 32'h0000_0055);
        wait_end(0, 200, gd, ge);
        chk1("post_rst_write_done", gd, 1'b1);
        issue(0, 1'b0, 32'h3800_0030, 4'hF, 8'd1, 1, 32'h0);
        wait_end(0, 200, gd, ge);
        chk1("post_rst_read_done", gd, 1'b1);
        chk("post_rst_queues_drained", 32'(bus_q.size() + rd_q.size()), 32'd0);

        // Timeout on the TIMEOUT=8 instance: responder never acks.
        noack[1] = 1'b1;
        s0 = n_stb;
        e0 = n_err;
        d0 = n_done;
        issue(1, 1'b0, 32'h3800_0000, 4'hF, 8'd2, 0, 32'h0);
        wait_end(1, 100, gd, ge);
        chk1("to_err", ge, 1'b1);
        chk1("to_no_done", gd, 1'b0);
        chk("to_stb_cycles", 32'(n_stb - s0), 32'd8);
        bus_q.delete();
        rd_q.delete();
        repeat (4) @(negedge clk);
        chk("to_err_once", 32'(n_err - e0), 32'd1);
        chk("to_done_none", 32'(n_done - d0), 32'd0);
        chk1("to_cyc_idle", cyc[1], 1'b0);
        noack[1] = 1'b0;
        issue(1, 1'b0, 32'h3800_0004, 4'hF, 8'd0, 0, 32'h0);
        wait_end(1, 100, gd, ge);
        chk1("to_next_cmd_done", gd, 1'b1);

        // Address wrap, each ack landing on the timeout cycle.
        s0 = n_stb;
        issue(1, 1'b0, 32'hFFFF_FFFC, 4'hF, 8'd1, 7, 32'h0);
        wait_end(1, 100, gd, ge);
        chk1("wrap_done", gd, 1'b1);
        chk1("wrap_no_err", ge, 1'b0);
        chk("wrap_stb_cycles", 32'(n_stb - s0), 32'd16);
        chk("wrap_queues_drained", 32'(bus_q.size() + rd_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
